// File: rtl/tdm_demux2_if.sv
// Serial-in / dual-word-out bus between a TDM link and the 2-channel demux.
interface tdm_demux2_if #(
    parameter int unsigned WIDTH = 8
);
    logic             bit_in;
    logic             sel;
    logic             bit_valid;
    logic             flush;
    logic [WIDTH-1:0] out_a;
    logic             valid_a;
    logic [WIDTH-1:0] out_b;
    logic             valid_b;
    logic             err;

    modport master (
        output bit_in, sel, bit_valid, flush,
        input  out_a, valid_a, out_b, valid_b, err
    );

    modport slave (
        input  bit_in, sel, bit_valid, flush,
        output out_a, valid_a, out_b, valid_b, err
    );
endinterface

// File: rtl/tdm_demux2.sv
// 2-channel TDM bit demultiplexer: rebuilds MSB-first words per channel tag.
// Optional TDM_PARITY_EN: each word is followed by an even-parity bit checked before release.
module tdm_demux2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    tdm_demux2_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh    [2];
    logic [CW-1:0]    cnt   [2];
    logic [WIDTH-1:0] word  [2];
    logic             valid [2];
    logic [WIDTH-1:0] next_c;

    // Shift-register contents of the selected channel after accepting bit_in
    assign next_c = {sh[bus.sel][WIDTH-2:0], bus.bit_in};

`ifdef TDM_PARITY_EN
    typedef enum logic {S_DATA, S_PAR} pstate_t;
    pstate_t          pst  [2];
    logic [WIDTH-1:0] pend [2];
    logic             err_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                sh[i]    <= '0;
                cnt[i]   <= '0;
                word[i]  <= '0;
                valid[i] <= 1'b0;
                pend[i]  <= '0;
                pst[i]   <= S_DATA;
            end
            err_r <= 1'b0;
        end else begin
            valid[0] <= 1'b0;
            valid[1] <= 1'b0;
            if (bus.flush) begin
                for (int i = 0; i < 2; i++) begin
                    sh[i]  <= '0;
                    cnt[i] <= '0;
                    pst[i] <= S_DATA;
                end
            end else if (bus.bit_valid) begin
                if (pst[bus.sel] == S_PAR) begin
                    // Even parity: word XOR parity bit must be zero
                    if ((^pend[bus.sel]) == bus.bit_in) begin
                        word[bus.sel]  <= pend[bus.sel];
                        valid[bus.sel] <= 1'b1;
                    end else begin
                        err_r <= 1'b1;
                    end
                    pst[bus.sel] <= S_DATA;
                end else begin
                    sh[bus.sel] <= next_c;
                    if (cnt[bus.sel] == LAST) begin
                        pend[bus.sel] <= next_c;
                        cnt[bus.sel]  <= '0;
                        pst[bus.sel]  <= S_PAR;
                    end else begin
                        cnt[bus.sel] <= cnt[bus.sel] + CW'(1);
                    end
                end
            end
        end
    end

    assign bus.err = err_r;
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                sh[i]    <= '0;
                cnt[i]   <= '0;
                word[i]  <= '0;
                valid[i] <= 1'b0;
            end
        end else begin
            valid[0] <= 1'b0;
            valid[1] <= 1'b0;
            if (bus.flush) begin
                for (int i = 0; i < 2; i++) begin
                    sh[i]  <= '0;
                    cnt[i] <= '0;
                end
            end else if (bus.bit_valid) begin
                sh[bus.sel] <= next_c;
                if (cnt[bus.sel] == LAST) begin
                    word[bus.sel]  <= next_c;
                    valid[bus.sel] <= 1'b1;
                    cnt[bus.sel]   <= '0;
                end else begin
                    cnt[bus.sel] <= cnt[bus.sel] + CW'(1);
                end
            end
        end
    end

    assign bus.err = 1'b0;
`endif

    assign bus.out_a   = word[0];
    assign bus.valid_a = valid[0];
    assign bus.out_b   = word[1];
    assign bus.valid_b = valid[1];
endmodule

// File: doc/tdm_demux2.md
Name: tdm_demux2

Overview:
- Receive-side counterpart of the 2:1 bit multiplexer.
- Takes a single time-multiplexed serial bit stream, tagged per bit with a channel select, and rebuilds two independent parallel words, channel A (sel=0) and channel B (sel=1).
- Each completed word is presented with a one-cycle valid strobe.
- Sits downstream of the mux/link; feeds word-level consumers.

Parameters:
- WIDTH, 8, bits per reassembled word per channel; legal range 2..32.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit.
- sel  input  1  channel tag for bit_in; 0 = channel A, 1 = channel B.
- bit_valid  input  1  bit_in/sel are meaningful this cycle.
- flush  input  1  discard partial words on both channels.
- out_a  output  WIDTH  last completed channel A word.
- valid_a  output  1  one-cycle strobe: out_a updated.
- out_b  output  WIDTH  last completed channel B word.
- valid_b  output  1  one-cycle strobe: out_b updated.
- err  output  1  sticky error flag; only driven when TDM_PARITY_EN is defined, else tied 0.

Behaviour:
- Reset (sync, active-high, sampled on posedge clock):
  - Clears out_a, out_b, both shift registers and both bit counters to 0.
  - Clears valid_a, valid_b and err to 0.
  - Overrides every other input in the same cycle.
- Per-channel datapath: WIDTH-bit shift register sh_x and counter cnt_x (range 0..WIDTH-1; width $clog2(WIDTH), minimum 1).
- Bit acceptance: on posedge with bit_valid=1, flush=0, reset=0, only the channel selected by sel updates:
  - sh_x <= {sh_x[WIDTH-2:0], bit_in}. MSB-first: the first bit received ends in out_x[WIDTH-1].
  - If cnt_x < WIDTH-1: cnt_x <= cnt_x+1.
  - If cnt_x == WIDTH-1 (word complete): out_x <= {sh_x[WIDTH-2:0], bit_in}; valid_x <= 1; cnt_x <= 0.
- Latency: valid_x is high in the cycle after the posedge that accepted the WIDTH-th bit. It lasts exactly one cycle unless another word completes on the very next edge.
- Hold behaviour:
  - out_x holds its value until the next completed word on that channel.
  - Partial words are never visible on out_x.
- The unselected channel's sh/cnt are untouched. Channels interleave arbitrarily; one channel may receive any number of consecutive bits.
- valid_a and valid_b can never be high in the same cycle (at most one bit is accepted per cycle).
- bit_valid=0: no state change; valid strobes drop to 0.
- Flush:
  - cnt_a, cnt_b, sh_a, sh_b are cleared; out_a/out_b are held.
  - valid_a/valid_b are 0 next cycle; err is held.
  - flush and bit_valid in the same cycle: flush wins and the bit is dropped.
- Reset mid-word: partial data is lost; the first bit after reset deasserts starts a fresh word on each channel.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined: each channel has a 2-state FSM, DATA then PAR.
  - DATA: behaves as above, except that on the WIDTH-th bit the word is latched into a pending register instead of out_x, no strobe is issued, and the FSM moves to PAR.
  - PAR: the next accepted bit for that channel is an even-parity bit.
  - PAR, parity correct (XOR of word and parity bit = 0): out_x <= pending; valid_x pulses.
  - PAR, parity wrong: out_x is held, no strobe, err <= 1 (sticky until reset).
  - In either case the FSM returns to DATA with cnt_x=0.
  - Flush or reset returns both FSMs to DATA. Effective latency: WIDTH+1 channel bits.
- Undefined: no FSM, no pending register; err is constant 0.

Test Plan:
- Reset: assert reset 2 cycles with bit_valid=1 and random bits -> out_a=out_b=0, valid_a=valid_b=0, err=0 throughout.
- Single channel A, WIDTH=8: send bits 1,0,1,1,0,0,1,0 with sel=0 on consecutive cycles -> one cycle after the 8th edge, out_a=8'hB2 and valid_a=1 for exactly 1 cycle; out_b stays 0.
- Interleave: alternate sel 0/1 with A stream 8'hA5 and B stream 8'h3C -> valid_a with out_a=8'hA5 then, one cycle later, valid_b with out_b=8'h3C; never both high together.
- Flush mid-word: send 5 bits to channel B, pulse flush with bit_valid=1, then send 8'hFF -> bit dropped, out_b=8'hFF after exactly 8 further B bits, no earlier strobe.
- Reset mid-word: send 3 bits of A, reset 1 cycle, then send 8'h01 -> out_a=8'h01 with a single valid_a.
- TDM_PARITY_EN: channel A sends 8'h03 with parity 0 -> out_a=8'h03, valid_a; then 8'h07 with parity 0 -> no strobe, out_a stays 8'h03, err=1 and held.
